// File: rtl/barcode_entry_controller_pkg.sv
// Shared constants and types for the barcode entry controller: key codes,
// digit capacity and the controller state encoding.
package barcode_entry_controller_pkg;

  // Key codes presented on KEY_CODE; 12..15 are unused and ignored.
  localparam logic [3:0] KEY_ENTER = 4'd10;
  localparam logic [3:0] KEY_CLEAR = 4'd11;
  localparam logic [3:0] KEY_BLANK = 4'd12;

  // Number of digits that make up one complete barcode.
  localparam logic [2:0] MAX_DIGITS = 3'd4;

  typedef enum logic [1:0] {
    ST_ENTRY    = 2'd0,
    ST_REQUEST  = 2'd1,
    ST_CLEARING = 2'd2
  } state_t;

  // True for the numeric keys 0..9.
  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/barcode_entry_controller_timer.sv
// Lookup timeout timer: restarts from zero on start, counts every cycle while
// running, and flags expiry when the count reaches TIMEOUT_CYCLES-1.
module lookup_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int TO_W           = 20
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST_COUNT = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_count;
  logic            r_running;
  logic            w_at_last;

  assign w_at_last = (r_count == LAST_COUNT);
  assign expired   = r_running && w_at_last;

  // Count while running; hold at the last value so the counter cannot wrap.
  always_ff @(posedge CLOCK) begin
    if (RESET || clear) begin
      r_running <= 1'b0;
      r_count   <= '0;
    end else if (start) begin
      r_running <= 1'b1;
      r_count   <= '0;
    end else if (r_running && !w_at_last) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/barcode_entry_controller.sv
// Barcode entry controller: collects four digit keys into an external shift
// register, issues a price lookup on ENTER, and clears the entry afterwards.
// Every output is registered and reflects the state the controller moves to.
module barcode_entry_controller
  import barcode_entry_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int TO_W           = 20
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       KEY_VALID,
  input  logic [3:0] KEY_CODE,
  input  logic       LOOKUP_ACK,
  input  logic       LOOKUP_FOUND,
  output logic [3:0] SR_DIGIT,
  output logic       SR_ENABLE,
  output logic       SR_RESET_N,
  output logic [2:0] DIGIT_COUNT,
  output logic       LOOKUP_REQ,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERROR
);

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] r_count;
  logic [2:0] w_next_count;

  logic [3:0] r_sr_digit;
  logic       r_sr_enable;
  logic       r_sr_reset_n;
  logic       r_lookup_req;
  logic       r_busy;
  logic       r_done;
  logic       r_error;

  logic       w_shift;
  logic       w_error;
  logic       w_done;
  logic       w_start_timer;
  logic       w_clear_timer;
  logic       w_timer_expired;

  logic       w_key_digit;
  logic       w_key_enter;
  logic       w_key_clear;

  assign w_key_digit = KEY_VALID && is_digit(KEY_CODE);
  assign w_key_enter = KEY_VALID && (KEY_CODE == KEY_ENTER);
  assign w_key_clear = KEY_VALID && (KEY_CODE == KEY_CLEAR);

  lookup_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_timer (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .start  (w_start_timer),
    .clear  (w_clear_timer),
    .expired(w_timer_expired)
  );

  // State register.
  always_ff @(posedge CLOCK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (RESET) r_state <= ST_ENTRY;
    else       r_state <= w_next_state;
  end

  // Next-state and per-cycle actions; lookup ACK outranks CLEAR, which
  // outranks the timeout.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_next_state  = r_state;
    w_next_count  = r_count;
    w_shift       = 1'b0;
    w_error       = 1'b0;
    w_done        = 1'b0;
    w_start_timer = 1'b0;

    case (r_state)
      ST_ENTRY: begin
        if (w_key_clear) begin
          w_next_state = ST_CLEARING;
        end else if (w_key_digit) begin
          if (r_count < MAX_DIGITS) begin
            w_shift      = 1'b1;
            w_next_count = r_count + 3'd1;
          end else begin
            w_error = 1'b1;
          end
        end else if (w_key_enter) begin
          if (r_count == MAX_DIGITS) begin
            w_next_state  = ST_REQUEST;
            w_start_timer = 1'b1;
          end else begin
            w_error = 1'b1;
          end
        end
      end
      ST_REQUEST: begin
        if (LOOKUP_ACK) begin
          w_done       = LOOKUP_FOUND;
          w_error      = !LOOKUP_FOUND;
          w_next_state = ST_CLEARING;
        end else if (w_key_clear) begin
          w_next_state = ST_CLEARING;
        end else if (w_timer_expired) begin
          w_error      = 1'b1;
          w_next_state = ST_CLEARING;
        end
      end
      ST_CLEARING: begin
        w_next_state = ST_ENTRY;
      end
      default: begin
        w_next_state = ST_ENTRY;
      end
    endcase

    if (w_next_state == ST_CLEARING) w_next_count = '0;
  end

  assign w_clear_timer = (r_state == ST_REQUEST) && (w_next_state != ST_REQUEST);

  // Digit count and registered outputs, derived from the state being entered.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_count      <= '0;
      r_sr_digit   <= KEY_BLANK;
      r_sr_enable  <= 1'b0;
      r_sr_reset_n <= 1'b0;
      r_lookup_req <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_count      <= w_next_count;
      if (w_shift) r_sr_digit <= KEY_CODE;
      r_sr_enable  <= w_shift;
      r_sr_reset_n <= (w_next_state != ST_CLEARING);
      r_lookup_req <= (w_next_state == ST_REQUEST);
      r_busy       <= (w_next_state != ST_ENTRY);
      r_done       <= w_done;
      r_error      <= w_error;
    end
  end

  assign SR_DIGIT    = r_sr_digit;
  assign SR_ENABLE   = r_sr_enable;
  assign SR_RESET_N  = r_sr_reset_n;
  assign DIGIT_COUNT = r_count;
  assign LOOKUP_REQ  = r_lookup_req;
  assign BUSY        = r_busy;
  assign DONE        = r_done;
  assign ERROR       = r_error;

endmodule

// File: tb/tb_barcode_entry_controller.sv
// Bench for barcode_entry_controller: directed scenarios followed by random
// key/ack traffic, all compared cycle by cycle against a behavioural model.
module tb_barcode_entry_controller;

  localparam int TO_CYC = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic       lookup_ack;
  logic       lookup_found;
  logic [3:0] sr_digit;
  logic       sr_enable;
  logic       sr_reset_n;
  logic [2:0] digit_count;
  logic       lookup_req;
  logic       busy;
  logic       done;
  logic       error;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: digits held in a queue, lookup tracked by a flag and
  // a wait counter, one-cycle clear tracked by a pending flag.
  int m_digits[$];
  bit m_requesting;
  bit m_clearing;
  int m_wait;
  int e_sr_digit;
  bit e_sr_enable, e_sr_reset_n, e_req, e_busy, e_done, e_error;

  barcode_entry_controller #(
    .TIMEOUT_CYCLES(TO_CYC),
    .TO_W          (4)
  ) dut (
    .CLOCK       (clock),
    .RESET       (reset),
    .KEY_VALID   (key_valid),
    .KEY_CODE    (key_code),
    .LOOKUP_ACK  (lookup_ack),
    .LOOKUP_FOUND(lookup_found),
    .SR_DIGIT    (sr_digit),
    .SR_ENABLE   (sr_enable),
    .SR_RESET_N  (sr_reset_n),
    .DIGIT_COUNT (digit_count),
    .LOOKUP_REQ  (lookup_req),
    .BUSY        (busy),
    .DONE        (done),
    .ERROR       (error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_step(input bit rst, input bit kv, input int kc, input bit ack, input bit found);
    bit go_clear = 1'b0;
    if (rst) begin
      m_digits.delete();
      m_requesting = 0; m_clearing = 0; m_wait = 0;
      e_sr_digit = 12; e_sr_enable = 0; e_sr_reset_n = 0;
      e_req = 0; e_busy = 0; e_done = 0; e_error = 0;
      return;
    end
    e_sr_enable = 0; e_done = 0; e_error = 0;
    if (m_clearing) begin
      m_clearing = 0;
    end else if (m_requesting) begin
      if (ack) begin
        e_done = found; e_error = !found; go_clear = 1;
      end else if (kv && kc == 11) begin
        go_clear = 1;
      end else if (m_wait == TO_CYC - 1) begin
        e_error = 1; go_clear = 1;
      end else begin
        m_wait++;
      end
    end else if (kv) begin
      if (kc == 11) go_clear = 1;
      else if (kc <= 9) begin
        if (m_digits.size() < 4) begin
          m_digits.push_back(kc); e_sr_enable = 1; e_sr_digit = kc;
        end else e_error = 1;
      end else if (kc == 10) begin
        if (m_digits.size() == 4) begin
          m_requesting = 1; m_wait = 0;
        end else e_error = 1;
      end
    end
    if (go_clear) begin
      m_requesting = 0; m_clearing = 1; m_digits.delete();
    end
    e_req        = m_requesting;
    e_busy       = m_requesting || m_clearing;
    e_sr_reset_n = !m_clearing;
  endtask

  // Apply one cycle of inputs, advance the model at the edge, compare after it.
  task automatic do_cycle(input bit rst, input bit kv, input int kc, input bit ack, input bit found);
    reset = rst; key_valid = kv; key_code = 4'(kc); lookup_ack = ack; lookup_found = found;
    @(posedge clock);
    model_step(rst, kv, kc, ack, found);
    #1;
    if (e_sr_enable || rst) check("sr_digit", 32'(sr_digit), 32'(e_sr_digit));
    check("sr_enable",  32'(sr_enable),   32'(e_sr_enable));
    check("sr_reset_n", 32'(sr_reset_n),  32'(e_sr_reset_n));
    check("count",      32'(digit_count), 32'(m_digits.size()));
    check("lookup_req", 32'(lookup_req),  32'(e_req));
    check("busy",       32'(busy),        32'(e_busy));
    check("done",       32'(done),        32'(e_done));
    check("error",      32'(error),       32'(e_error));
    if (sr_enable && !sr_reset_n) check("en_vs_clr", 32'd1, 32'd0);
  endtask

  task automatic idle();
    do_cycle(0, 0, 0, 0, 0);
  endtask

  task automatic key(input int kc);
    do_cycle(0, 1, kc, 0, 0);
  endtask

  task automatic enter_four();
    for (int i = 1; i <= 4; i++) key(i);
    key(10);
  endtask

  int req_cycles;
  bit saw_drop;

  initial begin
    // Reset state.
    for (int i = 0; i < 3; i++) do_cycle(1, 0, 0, 0, 0);
    check("rst_sr_digit", 32'(sr_digit), 32'd12);
    check("rst_sr_reset_n", 32'(sr_reset_n), 32'd0);
    idle();
    check("rel_sr_reset_n", 32'(sr_reset_n), 32'd1);

    // Four digits shift in.
    for (int i = 1; i <= 4; i++) begin
      key(i);
      check("shift_en", 32'(sr_enable), 32'd1);
      check("shift_digit", 32'(sr_digit), 32'(i));
    end
    check("count_full", 32'(digit_count), 32'd4);

    // Fifth digit rejected, ENTER starts the lookup.
    key(5);
    check("over_error", 32'(error), 32'd1);
    check("over_no_en", 32'(sr_enable), 32'd0);
    check("over_count", 32'(digit_count), 32'd4);
    key(10);
    check("enter_req", 32'(lookup_req), 32'd1);
    check("enter_busy", 32'(busy), 32'd1);
    key(7);
    key(10);
    check("req_keys_drop", 32'(error), 32'd0);

    // ACK found: DONE, one clear cycle, back to idle.
    do_cycle(0, 0, 0, 1, 1);
    check("ack_done", 32'(done), 32'd1);
    check("ack_clr", 32'(sr_reset_n), 32'd0);
    check("ack_count", 32'(digit_count), 32'd0);
    idle();
    check("ack_busy", 32'(busy), 32'd0);
    check("ack_clr_end", 32'(sr_reset_n), 32'd1);

    // ACK not found: ERROR instead of DONE.
    enter_four();
    do_cycle(0, 0, 0, 1, 0);
    check("nf_error", 32'(error), 32'd1);
    check("nf_done", 32'(done), 32'd0);
    idle();

    // Timeout: request held exactly TO_CYC cycles, then ERROR and clear.
    enter_four();
    req_cycles = lookup_req ? 1 : 0;
    saw_drop = 0;
    for (int i = 0; i < 3 * TO_CYC && !saw_drop; i++) begin
      idle();
      if (lookup_req) req_cycles++;
      else begin
        saw_drop = 1;
        check("to_error", 32'(error), 32'd1);
        check("to_clr", 32'(sr_reset_n), 32'd0);
      end
    end
    check("to_dropped", 32'(saw_drop), 32'd1);
    check("to_len", 32'(req_cycles), 32'(TO_CYC));
    idle();

    // ENTER short, then CLEAR with ACK together takes the DONE path.
    key(3); key(4); key(10);
    check("short_error", 32'(error), 32'd1);
    check("short_no_req", 32'(lookup_req), 32'd0);
    key(11);
    idle();
    enter_four();
    do_cycle(0, 1, 11, 1, 1);
    check("clr_ack_done", 32'(done), 32'd1);
    idle();

    // Unused codes and stray ACK are ignored.
    key(13);
    check("unused_err", 32'(error), 32'd0);
    do_cycle(0, 0, 0, 1, 1);
    check("stray_ack", 32'(done), 32'd0);

    // Reset in the middle of a request.
    key(11); idle();
    enter_four();
    do_cycle(1, 0, 0, 0, 0);
    check("midrst_req", 32'(lookup_req), 32'd0);
    check("midrst_clr", 32'(sr_reset_n), 32'd0);
    check("midrst_count", 32'(digit_count), 32'd0);
    check("midrst_flags", 32'({done, error}), 32'd0);
    idle();

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      int r, kc;
      bit kv, ack, rst;
      r = int'($urandom_range(0, 99));
      if (r < 70) kc = int'($urandom_range(0, 9));
      else if (r < 85) kc = 10;
      else if (r < 92) kc = 11;
      else kc = int'($urandom_range(12, 15));
      kv  = ($urandom_range(0, 99) < 55);
      ack = ($urandom_range(0, 99) < 12);
      rst = ($urandom_range(0, 999) < 5);
      do_cycle(rst, kv, kc, ack, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
